// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the multi-cycle ALU decoder and its iterative
// multiply/divide unit.
package alu_ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluAnd   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluXor   = 4'd4;
  localparam logic [3:0] AluSlt   = 4'd5;
  localparam logic [3:0] AluSltu  = 4'd6;
  localparam logic [3:0] AluSll   = 4'd7;
  localparam logic [3:0] AluSrl   = 4'd8;
  localparam logic [3:0] AluSra   = 4'd9;
  localparam logic [3:0] AluPassb = 4'd10;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef enum logic [1:0] {MdMul, MdMulhu, MdDivu, MdRemu} md_op_e;

  typedef struct packed {
    logic [3:0] alu;
    logic       illegal;
    logic       is_m;
    md_op_e     md_op;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between the main controller and alu_ctrl_seq.
interface alu_ctrl_seq_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 4
) ();
  logic              valid_in;
  logic              ready_out;
  logic [6:0]        op;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic              valid_out;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              md_sel;
  logic [XLEN-1:0]   md_result;
  logic              illegal;

  modport master (
    output valid_in, op, funct3, funct7, rs1_val, rs2_val,
    input  ready_out, valid_out, alu_ctrl, md_sel, md_result, illegal
  );

  modport slave (
    input  valid_in, op, funct3, funct7, rs1_val, rs2_val,
    output ready_out, valid_out, alu_ctrl, md_sel, md_result, illegal
  );
endinterface

// File: rtl/md_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide datapath.
// Loaded by start_i, advanced one bit per step_i; sequencing lives in the parent.
module md_iter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, a_q, a_d;
  md_op_e          op_q, op_d;
  logic            dz_q, dz_d;
  logic [XLEN:0]   sum, trial;
  logic            qbit;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    a_d   = a_q;
    op_d  = op_q;
    dz_d  = dz_q;
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    trial = {hi_q, lo_q[XLEN-1]};
    qbit  = (trial >= {1'b0, b_q});
    if (start_i) begin
      hi_d = '0;
      lo_d = a_i;
      b_d  = b_i;
      a_d  = a_i;
      op_d = op_i;
      dz_d = (b_i == '0);
    end else if (step_i) begin
      if (op_q == MdMul || op_q == MdMulhu) begin
        // {carry, hi, lo} shifts right one bit per step
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
      end else begin
        hi_d = qbit ? XLEN'(trial - {1'b0, b_q}) : trial[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], qbit};
      end
    end
  end

  // Reflects the pending step so the parent can capture it on the last edge.
  always_comb begin
    result_o = '0;
    case (op_q)
      MdMul:   result_o = lo_d;
      MdMulhu: result_o = hi_d;
      MdDivu:  result_o = dz_q ? '1 : lo_d;
      MdRemu:  result_o = dz_q ? a_q : hi_d;
      default: result_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
      a_q  <= '0;
      op_q <= MdMul;
      dz_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
      a_q  <= a_d;
      op_q <= op_d;
      dz_q <= dz_d;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered RV32I ALU-control decoder with an iterative MUL/MULHU/DIVU/REMU path
// and a valid/ready handshake with fixed latency.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 4
) (
  input logic           clk,
  input logic           rst,
  alu_ctrl_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(XLEN);

  function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7);
    dec_t d;
    d.alu     = AluAdd;
    d.illegal = 1'b0;
    d.is_m    = 1'b0;
    d.md_op   = MdMul;
    case (op)
      OpR: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0:    d.alu = AluAdd;
            3'd1:    d.alu = AluSll;
            3'd2:    d.alu = AluSlt;
            3'd3:    d.alu = AluSltu;
            3'd4:    d.alu = AluXor;
            3'd5:    d.alu = AluSrl;
            3'd6:    d.alu = AluOr;
            default: d.alu = AluAnd;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          d.alu = AluSub;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          d.alu = AluSra;
        end else if (f7 == 7'h01) begin
          case (f3)
            3'd0: begin d.is_m = 1'b1; d.md_op = MdMul;   end
            3'd3: begin d.is_m = 1'b1; d.md_op = MdMulhu; end
            3'd5: begin d.is_m = 1'b1; d.md_op = MdDivu;  end
            3'd7: begin d.is_m = 1'b1; d.md_op = MdRemu;  end
            default: d.illegal = 1'b1;
          endcase
        end else begin
          d.illegal = 1'b1;
        end
      end
      OpImm: begin
        case (f3)
          3'd0: d.alu = AluAdd;
          3'd1: begin
            if (f7 == 7'h00) d.alu = AluSll;
            else             d.illegal = 1'b1;
          end
          3'd2: d.alu = AluSlt;
          3'd3: d.alu = AluSltu;
          3'd4: d.alu = AluXor;
          3'd5: begin
            if (f7 == 7'h00)      d.alu = AluSrl;
            else if (f7 == 7'h20) d.alu = AluSra;
            else                  d.illegal = 1'b1;
          end
          3'd6:    d.alu = AluOr;
          default: d.alu = AluAnd;
        endcase
      end
      OpLoad, OpStore, OpJalr, OpJal, OpAuipc: d.alu = AluAdd;
      OpLui: d.alu = AluPassb;
      OpBranch: begin
        case (f3)
          3'd0, 3'd1: d.alu = AluSub;
          3'd4, 3'd5: d.alu = AluSlt;
          3'd6, 3'd7: d.alu = AluSltu;
          default:    d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d, valid_q, valid_d;
  logic [CTRL_W-1:0] alu_q, alu_d;
  logic              md_sel_q, md_sel_d, illegal_q, illegal_d;
  logic [XLEN-1:0]   md_res_q, md_res_d, md_res_next;
  dec_t              dec;
  logic              accept;

  assign dec    = decode(bus.op, bus.funct3, bus.funct7);
  assign accept = (state_q == StIdle) && bus.valid_in;

  md_iter #(
    .XLEN(XLEN)
  ) u_md_iter (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (accept && dec.is_m),
    .step_i   (state_q == StRun),
    .op_i     (dec.md_op),
    .a_i      (bus.rs1_val),
    .b_i      (bus.rs2_val),
    .result_o (md_res_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_d     = alu_q;
    md_sel_d  = md_sel_q;
    illegal_d = illegal_q;
    md_res_d  = md_res_q;
    case (state_q)
      StIdle: begin
        if (bus.valid_in) begin
          alu_d     = dec.is_m ? CTRL_W'(AluAdd) : CTRL_W'(dec.alu);
          illegal_d = dec.illegal;
          md_sel_d  = dec.is_m;
          md_res_d  = '0;
          if (dec.is_m) begin
            state_d = StRun;
            cnt_d   = CntW'(XLEN - 1);
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d  = StDone;
          md_res_d = md_res_next;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
    valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      alu_q     <= '0;
      md_sel_q  <= 1'b0;
      illegal_q <= 1'b0;
      md_res_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      alu_q     <= alu_d;
      md_sel_q  <= md_sel_d;
      illegal_q <= illegal_d;
      md_res_q  <= md_res_d;
    end
  end

  assign bus.ready_out = ready_q;
  assign bus.valid_out = valid_q;
  assign bus.alu_ctrl  = alu_q;
  assign bus.md_sel    = md_sel_q;
  assign bus.illegal   = illegal_q;
  assign bus.md_result = md_res_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: a transaction-level reference model checked every cycle,
// plus directed requests with literal expectations.
module tb_alu_ctrl_seq;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  alu_ctrl_seq_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  alu_ctrl_seq #(
    .XLEN   (XLEN),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference decode from the opcode tables, indexed by funct3.
  function automatic void mdec(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, output int code, output bit ill,
                               output bit ism, output int mop);
    int r_tab[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    int b_tab[8] = '{1, 1, 0, 0, 5, 5, 6, 6};
    code = 0; ill = 0; ism = 0; mop = 0;
    case (op)
      7'h33: begin
        if (f7 == 7'h00) code = r_tab[f3];
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) code = (f3 == 0) ? 1 : 9;
        else if (f7 == 7'h01 && f3 inside {3'd0, 3'd3, 3'd5, 3'd7}) begin
          ism = 1;
          mop = (f3 == 0) ? 0 : (f3 == 3) ? 1 : (f3 == 5) ? 2 : 3;
        end else ill = 1;
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          if (f7 == 7'h00) code = r_tab[f3];
          else if (f3 == 5 && f7 == 7'h20) code = 9;
          else ill = 1;
        end else code = r_tab[f3];
      end
      7'h03, 7'h23, 7'h67, 7'h6F, 7'h17: code = 0;
      7'h37: code = 10;
      7'h63: begin
        code = b_tab[f3];
        ill  = (f3 == 2 || f3 == 3);
      end
      default: ill = 1;
    endcase
  endfunction

  function automatic logic [31:0] mres(input int mop, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (mop)
      0:       return p[31:0];
      1:       return p[63:32];
      2:       return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Model state: pend = request in flight, rem = edges left until the valid cycle.
  bit          started = 0, pend = 0, e_valid = 0, e_sel = 0, e_ill = 0;
  int          rem = 0;
  logic [3:0]  e_alu = 0;
  logic [31:0] e_res = 0, m_final = 0;

  initial begin
    int  code, mop;
    bit  ill, ism;
    forever begin
      @(posedge clk);
      started = 1;
      if (rst) begin
        pend = 0; rem = 0; e_valid = 0; e_alu = 0; e_sel = 0; e_ill = 0; e_res = 0;
      end else if (pend) begin
        if (rem > 0) begin
          rem--;
          if (rem == 0) begin
            e_valid = 1;
            e_res   = m_final;
          end
        end else begin
          pend    = 0;
          e_valid = 0;
        end
      end else if (bus.valid_in) begin
        mdec(bus.op, bus.funct3, bus.funct7, code, ill, ism, mop);
        pend  = 1;
        e_res = 0;
        if (ism) begin
          e_alu = 0; e_ill = 0; e_sel = 1;
          m_final = mres(mop, bus.rs1_val, bus.rs2_val);
          rem     = XLEN;
          e_valid = 0;
        end else begin
          e_alu = 4'(code); e_ill = ill; e_sel = 0;
          rem     = 0;
          e_valid = 1;
        end
      end
      @(negedge clk);
      if (started) begin
        chk("cyc_ready", 64'(bus.ready_out), 64'(!pend));
        chk("cyc_valid", 64'(bus.valid_out), 64'(e_valid));
        chk("cyc_alu", 64'(bus.alu_ctrl), 64'(e_alu));
        chk("cyc_md_sel", 64'(bus.md_sel), 64'(e_sel));
        chk("cyc_illegal", 64'(bus.illegal), 64'(e_ill));
        if (!pend || e_valid) chk("cyc_md_result", 64'(bus.md_result), 64'(e_res));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready_out && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (!bus.ready_out) chk("ready_timeout", 64'(bus.ready_out), 64'd1);
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid_in = 1'b1;
    bus.op = o; bus.funct3 = f3; bus.funct7 = f7; bus.rs1_val = a; bus.rs2_val = b;
  endtask

  task automatic req(input string nm, input logic [6:0] o, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, input logic [3:0] ea, input logic ei,
                     input logic es, input logic [31:0] er);
    int lat;
    wait_ready();
    drive(o, f3, f7, a, b);
    @(posedge clk); #2;
    // Scramble fields after accept; the result must not depend on them.
    bus.valid_in = 1'b0;
    bus.op = 7'($urandom); bus.funct3 = 3'($urandom); bus.funct7 = 7'($urandom);
    bus.rs1_val = $urandom; bus.rs2_val = $urandom;
    lat = 1;
    while (!bus.valid_out && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_alu"}, 64'(bus.alu_ctrl), 64'(ea));
    chk({nm, "_illegal"}, 64'(bus.illegal), 64'(ei));
    chk({nm, "_md_sel"}, 64'(bus.md_sel), 64'(es));
    chk({nm, "_md_result"}, 64'(bus.md_result), 64'(er));
  endtask

  initial begin
    int  k, first_k, second_k;
    bit  seen;
    bus.valid_in = 0; bus.op = 0; bus.funct3 = 0; bus.funct7 = 0;
    bus.rs1_val = 0; bus.rs2_val = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_ready", 64'(bus.ready_out), 64'd1);
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_alu", 64'(bus.alu_ctrl), 64'd0);
    chk("rst_md_sel", 64'(bus.md_sel), 64'd0);
    chk("rst_md_result", 64'(bus.md_result), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);

    req("sub",      7'h33, 3'd0, 7'h20, 0, 0, 1, 4'd1,  1'b0, 1'b0, 0);
    req("r20_f6",   7'h33, 3'd6, 7'h20, 0, 0, 1, 4'd0,  1'b1, 1'b0, 0);
    req("and",      7'h33, 3'd7, 7'h00, 0, 0, 1, 4'd2,  1'b0, 1'b0, 0);
    req("sll",      7'h33, 3'd1, 7'h00, 0, 0, 1, 4'd7,  1'b0, 1'b0, 0);
    req("r01_f1",   7'h33, 3'd1, 7'h01, 0, 0, 1, 4'd0,  1'b1, 1'b0, 0);
    req("srai",     7'h13, 3'd5, 7'h20, 0, 0, 1, 4'd9,  1'b0, 1'b0, 0);
    req("slli_bad", 7'h13, 3'd1, 7'h20, 0, 0, 1, 4'd0,  1'b1, 1'b0, 0);
    req("xori",     7'h13, 3'd4, 7'h55, 0, 0, 1, 4'd4,  1'b0, 1'b0, 0);
    req("lui",      7'h37, 3'd0, 7'h00, 0, 0, 1, 4'd10, 1'b0, 1'b0, 0);
    req("store",    7'h23, 3'd2, 7'h00, 0, 0, 1, 4'd0,  1'b0, 1'b0, 0);
    req("bltu",     7'h63, 3'd6, 7'h00, 0, 0, 1, 4'd6,  1'b0, 1'b0, 0);
    req("br_f2",    7'h63, 3'd2, 7'h00, 0, 0, 1, 4'd0,  1'b1, 1'b0, 0);
    req("op7f",     7'h7F, 3'd0, 7'h00, 0, 0, 1, 4'd0,  1'b1, 1'b0, 0);

    req("mul",    7'h33, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'd2, 33, 4'd0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    req("mulhu",  7'h33, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'd2, 33, 4'd0, 1'b0, 1'b1, 32'h0000_0001);
    req("mulhu2", 7'h33, 3'd3, 7'h01, 32'h8000_0000, 32'h10, 33, 4'd0, 1'b0, 1'b1, 32'h8);
    req("divu",   7'h33, 3'd5, 7'h01, 32'd100, 32'd7, 33, 4'd0, 1'b0, 1'b1, 32'd14);
    req("remu",   7'h33, 3'd7, 7'h01, 32'd100, 32'd7, 33, 4'd0, 1'b0, 1'b1, 32'd2);
    req("divu0",  7'h33, 3'd5, 7'h01, 32'hDEAD_BEEF, 32'd0, 33, 4'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    req("remu0",  7'h33, 3'd7, 7'h01, 32'h1234, 32'd0, 33, 4'd0, 1'b0, 1'b1, 32'h1234);
    req("divu_b", 7'h33, 3'd5, 7'h01, 32'hFFFF_FFFF, 32'h10, 33, 4'd0, 1'b0, 1'b1, 32'h0FFF_FFFF);
    req("remu_b", 7'h33, 3'd7, 7'h01, 32'hFFFF_FFFF, 32'h10, 33, 4'd0, 1'b0, 1'b1, 32'hF);

    // Reset in the middle of a DIVU: back to idle, no pulse afterwards.
    wait_ready();
    drive(7'h33, 3'd5, 7'h01, 32'd1000, 32'd3);
    @(posedge clk); #2;
    bus.valid_in = 1'b0;
    repeat (9) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("abort_ready", 64'(bus.ready_out), 64'd1);
    chk("abort_valid", 64'(bus.valid_out), 64'd0);
    chk("abort_md_sel", 64'(bus.md_sel), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #2;
      if (bus.valid_out) seen = 1;
    end
    chk("abort_no_pulse", 64'(seen), 64'd0);

    // Request coinciding with reset is dropped.
    drive(7'h33, 3'd0, 7'h20, 0, 0);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    bus.valid_in = 1'b0;
    chk("rstreq_ready", 64'(bus.ready_out), 64'd1);
    chk("rstreq_alu", 64'(bus.alu_ctrl), 64'd0);
    @(posedge clk); #2;
    chk("rstreq_valid", 64'(bus.valid_out), 64'd0);

    // valid_in held across a DIVU while the fields switch to an ADDI.
    wait_ready();
    drive(7'h33, 3'd5, 7'h01, 32'd100, 32'd7);
    @(posedge clk); #2;
    bus.op = 7'h13; bus.funct3 = 3'd0; bus.funct7 = 7'h00;
    bus.rs1_val = 32'd5; bus.rs2_val = 32'd9;
    k = 1; first_k = 0; second_k = 0;
    while (second_k == 0 && k < 100) begin
      if (bus.valid_out) begin
        if (first_k == 0) begin
          first_k = k;
          chk("b2b_div_result", 64'(bus.md_result), 64'd14);
          chk("b2b_div_sel", 64'(bus.md_sel), 64'd1);
        end else begin
          second_k = k;
          bus.valid_in = 1'b0;
          chk("b2b_addi_alu", 64'(bus.alu_ctrl), 64'd0);
          chk("b2b_addi_sel", 64'(bus.md_sel), 64'd0);
        end
      end
      if (second_k == 0) begin
        @(posedge clk); #2;
        k++;
      end
    end
    bus.valid_in = 1'b0;
    chk("b2b_first_lat", 64'(first_k), 64'd33);
    chk("b2b_second_lat", 64'(second_k), 64'd35);
    repeat (3) begin @(posedge clk); #2; end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
